selector_decoder: RTL and testbench
===================================

Name: selector_decoder

Overview:
- Receive-side counterpart of the one-hot shift selector.
- Samples the one-hot select bus that the selector drives onto the pixel array, and converts it to a binary index.
- Buffers the index in a 1-deep output register with a valid/ready handshake for the readout/ADC sequencing logic.
- Flags malformed vectors (zero-hot, multi-hot), checks sweep order, and counts completed sweeps.

Parameters:
- length, 4, width of the one-hot select bus (number of selectable rows/columns), >=1
- count_width, 8, width of the completed-sweep counter
- Derived, not a parameter: IW = max(1, $clog2(length)), the index width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- select_in  input  length  one-hot select vector from the selector
- select_valid  input  1  select_in is meaningful this cycle (selector output enabled)
- select_ready  output  1  block can accept a sample this cycle
- out_ready  input  1  downstream accepts index this cycle
- index  output  IW  binary position of the set bit
- index_valid  output  1  index/index_last hold a buffered result
- index_last  output  1  buffered index == length-1 (end of sweep)
- sweep_count  output  count_width  number of completed sweeps, wraps modulo 2^count_width
- clear_error  input  1  clears error and error_code
- error  output  1  sticky error flag
- error_code  output  2  first error since clear: 01 zero-hot, 10 multi-hot, 11 order

Behaviour:
- Reset (clk edge with reset=1), all outputs and state go to 0:
  - index, index_valid, index_last, sweep_count, error, error_code.
  - Expected index set to 0.
  - Reset mid-operation discards any buffered index; reset overrides all other inputs.
- Ready and accept:
  - select_ready = !index_valid || out_ready (combinational).
  - Accept occurs when select_valid && select_ready.
  - A cycle with select_valid=0 has no effect on decode state.
- Decode on accept:
  - Exactly one bit set: index <= bit position, index_last <= (position == length-1), index_valid <= 1.
    - Latency: 1 clock from accept edge to index_valid.
    - Back-to-back accepts with out_ready=1 give full throughput.
  - Zero bits set: nothing buffered. error <= 1; error_code <= 01 if error was 0. If a buffered index is being consumed in that same cycle, index_valid <= 0.
  - Two or more bits set: same as zero-hot, but the code is 10.
- Output handshake:
  - index_valid && out_ready consumes the buffered entry.
  - If no valid one-hot accept happens in the same cycle, index_valid <= 0.
  - index/index_last hold stable while index_valid=1 && out_ready=0.
- Sweep tracking:
  - Expected index advances to (decoded+1) on every valid one-hot accept.
  - When the decoded index is length-1, the expected index wraps to 0 and sweep_count increments.
  - sweep_count wraps from 2^count_width-1 to 0 without a flag.
- Order check (only with the optional feature):
  - A valid one-hot accept whose index differs from the expected index is still forwarded.
  - It sets error; error_code <= 11 if error was 0.
  - The expected index resynchronises to decoded+1.
- Error priority:
  - error_code records only the first error; later errors leave it unchanged.
  - clear_error=1 with no new error in the same cycle: error <= 0, error_code <= 00.
  - clear_error=1 together with a new error: the new error wins (error=1, error_code=new code).
- length=1:
  - IW=1, index is always 0, index_last=1 on every valid entry.
  - Every valid accept increments sweep_count.

Optional Feature:
- Macro SELECTOR_DECODER_ORDER_CHECK_EN.
- Defined: expected-index tracking and the order check above are compiled in; error_code 11 is reachable.
- Undefined: no order check, error_code never 11, and expected-index storage is removed.
- Sweep counting still uses decoded == length-1 in both builds.

Test Plan:
- Reset, then length=4, out_ready=1, select_valid=1, select_in 0001, 0010, 0100, 1000 on consecutive cycles -> index 0,1,2,3 on the 4 cycles after each accept; index_last=1 only with 3; sweep_count=1; error=0.
- Backpressure: out_ready=0 while 0001 then 0010 are offered -> index_valid=1 with index=0 held; select_ready=0; 0010 not taken. Raise out_ready -> 0 consumed and 0010 accepted the same cycle; next cycle index=1.
- Offer select_in=0000, then 0110, then clear_error=1 -> after 0000: error=1, code=01, no index_valid. 0110 leaves code 01. clear_error returns error=0, code=00.
- With SELECTOR_DECODER_ORDER_CHECK_EN: accept 0001 then 0100 -> index 2 forwarded, error=1, code=11. Next 1000 gives no new error; sweep_count increments.
- count_width=2, run 4 full sweeps -> sweep_count 1,2,3,0. Assert reset mid-sweep after index 1 -> index_valid=0, sweep_count=0, next 0001 accepted with no order error.
- Same cycle: clear_error=1 and select_in=1100 accepted -> error=1, error_code=10.

Source files
------------

// File: rtl/selector_decoder.sv
// ============================================================================
// Module   : selector_decoder
// Purpose  : Converts a one-hot row/column select bus to a buffered binary
//            index with valid/ready handshake, error flags and sweep count.
//            Optional sweep-order check: SELECTOR_DECODER_ORDER_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module selector_decoder #(
    parameter int LENGTH      = 4,
    parameter int COUNT_WIDTH = 8,
    localparam int IW         = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LENGTH-1:0]      select_in,
    input  logic                   select_valid,
    output logic                   select_ready,
    input  logic                   out_ready,
    output logic [IW-1:0]          index,
    output logic                   index_valid,
    output logic                   index_last,
    output logic [COUNT_WIDTH-1:0] sweep_count,
    input  logic                   clear_error,
    output logic                   error,
    output logic [1:0]             error_code
);

    localparam logic [IW-1:0] c_last_idx   = IW'(LENGTH - 1);
    localparam logic [1:0]    c_code_zero  = 2'b01;
    localparam logic [1:0]    c_code_multi = 2'b10;
    localparam logic [1:0]    c_code_order = 2'b11;

    logic [IW-1:0]          r_index;
    logic                   r_valid;
    logic                   r_last;
    logic [COUNT_WIDTH-1:0] r_sweep;
    logic                   r_error;
    logic [1:0]             r_code;

    logic                   w_accept;
    logic                   w_zero;
    logic                   w_multi;
    logic                   w_good;
    logic                   w_is_last;
    logic                   w_order_err;
    logic                   w_new_err;
    logic [1:0]             w_new_code;
    logic [IW-1:0]          w_pos;

    assign select_ready = !r_valid || out_ready;
    assign w_accept     = select_valid && select_ready;

    // Clearing the lowest set bit leaves a nonzero residue only for multi-hot.
    assign w_zero  = (select_in == '0);
    assign w_multi = |(select_in & (select_in - LENGTH'(1)));
    assign w_good  = w_accept && !w_zero && !w_multi;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (select_in[i]) begin
                w_pos = w_pos | IW'(i);
            end
        end
    end

    assign w_is_last = (w_pos == c_last_idx);

`ifdef SELECTOR_DECODER_ORDER_CHECK_EN
    logic [IW-1:0] r_expected;

    assign w_order_err = w_good && (w_pos != r_expected);

    // Resynchronise on every good decode so one skip raises a single error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected <= '0;
        end else if (w_good) begin
            r_expected <= w_is_last ? '0 : (w_pos + IW'(1));
        end
    end
`else
    assign w_order_err = 1'b0;
`endif

    always_comb begin
        w_new_err  = 1'b0;
        w_new_code = 2'b00;
        if (w_accept && w_zero) begin
            w_new_err  = 1'b1;
            w_new_code = c_code_zero;
        end else if (w_accept && w_multi) begin
            w_new_err  = 1'b1;
            w_new_code = c_code_multi;
        end else if (w_order_err) begin
            w_new_err  = 1'b1;
            w_new_code = c_code_order;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sweep <= '0;
            r_error <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            if (w_good) begin
                r_index <= w_pos;
                r_last  <= w_is_last;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_good && w_is_last) begin
                r_sweep <= r_sweep + COUNT_WIDTH'(1);
            end

            // A new error in the clearing cycle is treated as the first error.
            if (w_new_err) begin
                r_error <= 1'b1;
                if (!r_error || clear_error) begin
                    r_code <= w_new_code;
                end
            end else if (clear_error) begin
                r_error <= 1'b0;
                r_code  <= 2'b00;
            end
        end
    end

    assign index       = r_index;
    assign index_valid = r_valid;
    assign index_last  = r_last;
    assign sweep_count = r_sweep;
    assign error       = r_error;
    assign error_code  = r_code;

endmodule

`default_nettype wire

// File: tb/tb_selector_decoder.sv
// ============================================================================
// Module   : tb_selector_decoder
// Purpose  : Scoreboard-based self-checking bench for selector_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_selector_decoder;

    localparam int LEN = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [LEN-1:0] select_in;
    logic           select_valid;
    logic           select_ready;
    logic           out_ready;
    logic [1:0]     index;
    logic           index_valid;
    logic           index_last;
    logic [CW-1:0]  sweep_count;
    logic           clear_error;
    logic           error;
    logic [1:0]     error_code;

    int checks = 0;
    int errors = 0;

    logic [2:0]    sb[$];
    logic [CW-1:0] exp_sweeps = '0;

    selector_decoder #(.LENGTH(LEN), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .select_in(select_in),
        .select_valid(select_valid), .select_ready(select_ready),
        .out_ready(out_ready), .index(index), .index_valid(index_valid),
        .index_last(index_last), .sweep_count(sweep_count),
        .clear_error(clear_error), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop on consumption, push on one-hot accept (inputs stable here).
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_sweeps = '0;
        end else begin
            if (index_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got index=%0d last=%0b, expected nothing buffered", index, index_last);
                end else begin
                    logic [2:0] e;
                    e = sb.pop_front();
                    if ({index_last, index} !== e) begin
                        errors++;
                        $display("FAIL sb_index: got last=%0b index=%0d, expected last=%0b index=%0d",
                                 index_last, index, e[2], e[1:0]);
                    end
                end
            end
            if (select_valid && select_ready && $onehot(select_in)) begin
                logic [1:0] p;
                p = 2'd0;
                for (int i = 0; i < LEN; i++) if (select_in[i]) p = 2'(i);
                sb.push_back({(p == 2'd3), p});
                if (p == 2'd3) exp_sweeps = exp_sweeps + 1'b1;
            end
        end
    end

    task automatic step(input logic v, input logic [LEN-1:0] s, input logic r, input logic c);
        select_valid = v;
        select_in    = s;
        out_ready    = r;
        clear_error  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if ({index_valid, index, index_last, sweep_count, error, error_code} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b i=%0d l=%0b sc=%0d e=%0b c=%0d, expected all 0",
                     index_valid, index, index_last, sweep_count, error, error_code);
        end
    endtask

    task automatic test_sweep();
        for (int b = 0; b < LEN; b++) step(1'b1, 4'(1 << b), 1'b1, 1'b0);
        checks++;
        if (index_valid !== 1'b1 || index !== 2'd3 || index_last !== 1'b1) begin
            errors++;
            $display("FAIL sweep_last: got v=%0b i=%0d l=%0b, expected v=1 i=3 l=1", index_valid, index, index_last);
        end
        checks++;
        if (sweep_count !== 2'd1 || error !== 1'b0) begin
            errors++;
            $display("FAIL sweep_count: got sc=%0d e=%0b, expected sc=1 e=0", sweep_count, error);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        checks++;
        if (index_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain: got index_valid=%0b, expected 0", index_valid);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        checks++;
        if (select_ready !== 1'b0 || index_valid !== 1'b1 || index !== 2'd0) begin
            errors++;
            $display("FAIL bp_stall: got rdy=%0b v=%0b i=%0d, expected rdy=0 v=1 i=0", select_ready, index_valid, index);
        end
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        checks++;
        if (index_valid !== 1'b1 || index !== 2'd0 || select_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%0b i=%0d rdy=%0b, expected v=1 i=0 rdy=0", index_valid, index, select_ready);
        end
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        checks++;
        if (index_valid !== 1'b1 || index !== 2'd1) begin
            errors++;
            $display("FAIL bp_release: got v=%0b i=%0d, expected v=1 i=1", index_valid, index);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_errors();
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        checks++;
        if (error !== 1'b1 || error_code !== 2'b01 || index_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_hot: got e=%0b c=%0d v=%0b, expected e=1 c=1 v=0", error, error_code, index_valid);
        end
        step(1'b1, 4'b0110, 1'b1, 1'b0);
        checks++;
        if (error !== 1'b1 || error_code !== 2'b01 || index_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_sticky: got e=%0b c=%0d v=%0b, expected e=1 c=1 v=0", error, error_code, index_valid);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b1);
        checks++;
        if (error !== 1'b0 || error_code !== 2'b00) begin
            errors++;
            $display("FAIL clear: got e=%0b c=%0d, expected e=0 c=0", error, error_code);
        end
    endtask

    task automatic test_order();
        logic [1:0] exp_code;
`ifdef SELECTOR_DECODER_ORDER_CHECK_EN
        exp_code = 2'b11;
`else
        exp_code = 2'b00;
`endif
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        step(1'b1, 4'b0100, 1'b1, 1'b0);
        checks++;
        if (index !== 2'd2 || error !== (exp_code != 2'b00) || error_code !== exp_code) begin
            errors++;
            $display("FAIL order_skip: got i=%0d e=%0b c=%0d, expected i=2 c=%0d", index, error, error_code, exp_code);
        end
        step(1'b1, 4'b1000, 1'b1, 1'b0);
        checks++;
        if (error_code !== exp_code || sweep_count !== exp_sweeps) begin
            errors++;
            $display("FAIL order_resync: got c=%0d sc=%0d, expected c=%0d sc=%0d", error_code, sweep_count, exp_code, exp_sweeps);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b1);
    endtask

    task automatic test_sweep_wrap();
        reset = 1'b1;
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < LEN; b++) step(1'b1, 4'(1 << b), 1'b1, 1'b0);
            checks++;
            if (sweep_count !== 2'((s + 1) % 4)) begin
                errors++;
                $display("FAIL sweep_wrap_%0d: got sc=%0d, expected %0d", s, sweep_count, (s + 1) % 4);
            end
        end
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 4'b0100, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if (index_valid !== 1'b0 || sweep_count !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b sc=%0d, expected v=0 sc=0", index_valid, sweep_count);
        end
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        checks++;
        if (index_valid !== 1'b1 || index !== 2'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got v=%0b i=%0d e=%0b, expected v=1 i=0 e=0", index_valid, index, error);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_clear_collision();
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b1100, 1'b1, 1'b1);
        checks++;
        if (error !== 1'b1 || error_code !== 2'b10) begin
            errors++;
            $display("FAIL clear_vs_new: got e=%0b c=%0d, expected e=1 c=2", error, error_code);
        end
        step(1'b0, 4'b0000, 1'b1, 1'b1);
    endtask

    initial begin
        reset        = 1'b0;
        select_in    = '0;
        select_valid = 1'b0;
        out_ready    = 1'b1;
        clear_error  = 1'b0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_errors();
        test_order();
        test_sweep_wrap();
        test_clear_collision();
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries never produced, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
